// File: rtl/tp_probe_mux.sv
// Test-point probe mux: any one of NCH x TPW test-point bits is routed to
// each of NOUT probe outputs and conditioned (direct/stretch/toggle/sticky).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   sel          per-output select {channel, bit} fields, SELW bits each
//   mode         per-output 2-bit conditioning mode
//   clr          per-output clear of toggle/sticky/stretch state and counter
//   tp           NCH test-point vectors of TPW bits
//   tp_out       registered conditioned probe outputs
//   evt_cnt      per-output saturating rising-edge counters, CNTW bits each
module tp_probe_mux #(
    parameter int  NCH     = 4,
    parameter int  TPW     = 32,
    parameter int  NOUT    = 2,
    parameter int  STRETCH = 8,
    parameter int  CNTW    = 16,
    localparam int BW      = $clog2(TPW),
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SELW    = CW + BW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NOUT*SELW-1:0] sel,
    input  logic [2*NOUT-1:0]    mode,
    input  logic [NOUT-1:0]      clr,
    input  logic [NCH*TPW-1:0]   tp,
    output logic [NOUT-1:0]      tp_out,
    output logic [NOUT*CNTW-1:0] evt_cnt
);

    localparam int SCW = $clog2(STRETCH + 1);

    logic [TPW-1:0] w_tpv [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_tpv[c] = tp[c*TPW +: TPW];
    end

    for (genvar i = 0; i < NOUT; i++) begin : g_out
        logic [SELW-1:0] w_sel;
        logic [1:0]      w_mode;
        logic            w_chg;
        logic            w_blank;
        logic            w_pick;
        logic            w_rise;
        logic            w_st_n;
        logic [SCW-1:0]  w_scnt_n;
        logic            w_out_n;

        logic [SELW-1:0] r_sel_q;
        logic [1:0]      r_mode_q;
        logic [1:0]      r_blank;
        logic            r_a;
        logic            r_b;
        logic            r_bd;
        logic            r_st;
        logic [SCW-1:0]  r_scnt;
        logic            r_out;
        logic [CNTW-1:0] r_cnt;

        assign w_sel   = sel[i*SELW +: SELW];
        assign w_mode  = mode[2*i +: 2];
        assign w_chg   = (w_sel != r_sel_q) || (w_mode != r_mode_q);
        assign w_blank = (r_blank != 2'd0);
        assign w_rise  = r_b & ~r_bd & ~w_blank;

        // Channel fields with no matching channel leave the pick at 0.
        always_comb begin
            w_pick = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (r_sel_q[SELW-1:BW] == CW'(c)) begin
                    w_pick = w_tpv[c][r_sel_q[BW-1:0]];
                end
            end
        end

        always_comb begin
            w_st_n   = r_st;
            w_scnt_n = r_scnt;
            w_out_n  = 1'b0;
            if (w_blank) begin
                w_st_n   = 1'b0;
                w_scnt_n = '0;
            end else if (clr[i]) begin
                w_st_n   = 1'b0;
                w_scnt_n = '0;
                w_out_n  = (r_mode_q == 2'd0) ? r_b : 1'b0;
            end else begin
                unique case (r_mode_q)
                    2'd0: w_out_n = r_b;
                    2'd1: begin
                        // Rise cycle itself is the first high cycle.
                        if (w_rise) begin
                            w_scnt_n = SCW'(STRETCH - 1);
                            w_out_n  = 1'b1;
                        end else if (r_scnt != '0) begin
                            w_scnt_n = r_scnt - 1'b1;
                            w_out_n  = 1'b1;
                        end
                    end
                    2'd2: begin
                        if (w_rise) w_st_n = ~r_st;
                        w_out_n = w_st_n;
                    end
                    2'd3: begin
                        if (w_rise) w_st_n = 1'b1;
                        w_out_n = w_st_n;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sel_q  <= '0;
                r_mode_q <= '0;
                r_blank  <= 2'd2;
                r_a      <= 1'b0;
                r_b      <= 1'b0;
                r_bd     <= 1'b0;
                r_st     <= 1'b0;
                r_scnt   <= '0;
                r_out    <= 1'b0;
                r_cnt    <= '0;
            end else begin
                if (w_chg) begin
                    r_sel_q  <= w_sel;
                    r_mode_q <= w_mode;
                    r_blank  <= 2'd2;
                end else if (w_blank) begin
                    r_blank <= r_blank - 2'd1;
                end
                r_a    <= w_pick;
                r_b    <= r_a;
                r_bd   <= r_b;
                r_st   <= w_st_n;
                r_scnt <= w_scnt_n;
                r_out  <= w_out_n;
                if (clr[i]) begin
                    r_cnt <= '0;
                end else if (w_rise && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign tp_out[i]               = r_out;
        assign evt_cnt[i*CNTW +: CNTW] = r_cnt;
    end

endmodule

// File: tb/tb_tp_probe_mux.sv
// Bench for tp_probe_mux: default instance plus a small instance
// (NCH=3, CNTW=4) for the unmapped-channel and saturation cases.
module tb_tp_probe_mux;

    typedef struct {
        int    cyc;
        int    kind;
        int    exp;
        string tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [13:0]  sel;
    logic [3:0]   mode;
    logic [1:0]   clr;
    logic [127:0] tp;
    logic [1:0]   tp_out;
    logic [31:0]  evt_cnt;

    logic [3:0]   sel2;
    logic [1:0]   mode2;
    logic [0:0]   clr2;
    logic [11:0]  tp2;
    logic [0:0]   tp_out2;
    logic [3:0]   evt2;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];
    exp_t keep[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tp_probe_mux u_dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .mode    (mode),
        .clr     (clr),
        .tp      (tp),
        .tp_out  (tp_out),
        .evt_cnt (evt_cnt)
    );

    tp_probe_mux #(
        .NCH     (3),
        .TPW     (4),
        .NOUT    (1),
        .STRETCH (2),
        .CNTW    (4)
    ) u_dut2 (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel2),
        .mode    (mode2),
        .clr     (clr2),
        .tp      (tp2),
        .tp_out  (tp_out2),
        .evt_cnt (evt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== 32'(exp))
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] obs(input int k);
        case (k)
            0:       obs = 32'(tp_out[0]);
            1:       obs = 32'(evt_cnt[15:0]);
            2:       obs = 32'(tp_out[1]);
            3:       obs = 32'(evt_cnt[31:16]);
            4:       obs = 32'(tp_out2);
            default: obs = 32'(evt2);
        endcase
    endfunction

    task automatic push(input int c, input int k, input int e, input string t);
        exp_t x;
        x.cyc  = c;
        x.kind = k;
        x.exp  = e;
        x.tag  = t;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        keep = {};
        foreach (q[j]) begin
            if (q[j].cyc <= cyc)
                check(q[j].tag, obs(q[j].kind), q[j].exp);
            else
                keep.push_back(q[j]);
        end
        q = keep;
    end

    initial begin
        int b;
        int c;
        int r0;
        int r1;
        int p0;
        int p1;
        int v0;
        int v1;

        sel   = {7'h03, 7'h23};
        mode  = '0;
        clr   = '0;
        tp    = '0;
        sel2  = 4'h9;
        mode2 = '0;
        clr2  = '0;
        tp2   = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) push(cyc, k, 0, "reset");
        repeat (6) step();

        // T1: direct mode, ch1 bit3 on out0, ch0 bit3 on out1
        r0 = 0; r1 = 0; p0 = 0; p1 = 0;
        for (int j = 0; j < 10; j++) begin
            v0 = int'(j % 2 == 0);
            v1 = int'(j % 3 == 0);
            tp[35] = v0[0];
            tp[3]  = v1[0];
            if (v0 == 1 && p0 == 0) r0++;
            if (v1 == 1 && p1 == 0) r1++;
            push(cyc + 3, 0, v0, "t1_out0");
            push(cyc + 3, 1, r0, "t1_cnt0");
            push(cyc + 3, 2, v1, "t1_out1");
            push(cyc + 3, 3, r1, "t1_cnt1");
            p0 = v0;
            p1 = v1;
            step();
        end
        repeat (4) step();
        push(cyc, 1, 5, "t1_total");

        // T2: stretch, single pulse then retriggered pair
        mode[1:0] = 2'd1;
        repeat (5) step();
        b = cyc;
        tp[35] = 1'b1;
        push(b + 2, 0, 0, "t2a_pre");
        for (int d = 3; d <= 10; d++) push(b + d, 0, 1, "t2a_hi");
        push(b + 11, 0, 0, "t2a_end");
        push(b + 3, 1, 6, "t2a_cnt");
        step();
        tp[35] = 1'b0;
        repeat (14) step();
        b = cyc;
        tp[35] = 1'b1;
        push(b + 2, 0, 0, "t2b_pre");
        for (int d = 3; d <= 14; d++) push(b + d, 0, 1, "t2b_hi");
        push(b + 15, 0, 0, "t2b_end");
        push(b + 3, 1, 7, "t2b_cnt1");
        push(b + 7, 1, 8, "t2b_cnt2");
        step();
        tp[35] = 1'b0;
        repeat (3) step();
        tp[35] = 1'b1;
        step();
        tp[35] = 1'b0;
        repeat (16) step();

        // T3: sticky, hold, clr, clr racing a rise
        mode[1:0] = 2'd3;
        repeat (5) step();
        b = cyc;
        tp[35] = 1'b1;
        push(b + 2, 0, 0, "t3_pre");
        push(b + 3, 0, 1, "t3_set");
        push(b + 50, 0, 1, "t3_hold50");
        push(b + 103, 0, 1, "t3_hold100");
        push(b + 3, 1, 9, "t3_cnt");
        step();
        tp[35] = 1'b0;
        repeat (104) step();
        c = cyc;
        clr[0] = 1'b1;
        push(c + 1, 0, 0, "t3_clr_out");
        push(c + 1, 1, 0, "t3_clr_cnt");
        push(c, 3, 4, "t3_cnt1");
        step();
        clr[0] = 1'b0;
        repeat (3) step();
        b = cyc;
        tp[35] = 1'b1;
        for (int d = 3; d <= 6; d++) begin
            push(b + d, 0, 0, "t3_race_out");
            push(b + d, 1, 0, "t3_race_cnt");
        end
        step();
        tp[35] = 1'b0;
        step();
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        repeat (6) step();

        // T4: select switch between two high bits blanks for 2 cycles
        mode[1:0] = 2'd0;
        sel[6:0]  = 7'h00;
        tp[0]     = 1'b1;
        tp[127]   = 1'b1;
        repeat (8) step();
        c = cyc;
        clr[0] = 1'b1;
        push(c + 1, 0, 1, "t4_clr_direct");
        push(c + 1, 1, 0, "t4_clr_cnt");
        step();
        clr[0] = 1'b0;
        repeat (2) step();
        b = cyc;
        sel[6:0] = 7'h7F;
        push(b + 1, 0, 1, "t4_before");
        push(b + 2, 0, 0, "t4_blank1");
        push(b + 3, 0, 0, "t4_blank2");
        push(b + 4, 0, 1, "t4_after");
        push(b + 5, 0, 1, "t4_after2");
        push(b + 6, 1, 0, "t4_nocount");
        repeat (8) step();

        // T6: toggle and stretch running, then reset mid-activity
        sel  = {7'h03, 7'h23};
        mode = {2'd2, 2'd1};
        tp[35] = 1'b0;
        tp[3]  = 1'b0;
        repeat (8) step();
        b = cyc;
        tp[3] = 1'b1;
        push(b + 3, 2, 1, "t6_tgl_on");
        push(b + 5, 2, 1, "t6_tgl_hold");
        push(b + 6, 2, 0, "t6_tgl_off");
        push(b + 7, 2, 0, "t6_tgl_off2");
        step();
        tp[3] = 1'b0;
        step();
        step();
        tp[3] = 1'b1;
        step();
        tp[3] = 1'b0;
        repeat (5) step();
        b = cyc;
        tp[35] = 1'b1;
        tp[3]  = 1'b1;
        push(b + 3, 0, 1, "t6_str_on");
        push(b + 4, 0, 1, "t6_str_on2");
        push(b + 3, 2, 1, "t6_tgl_on3");
        step();
        tp[35] = 1'b0;
        step();
        step();
        sel[13:7] = 7'h04;
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(b + 5, k, 0, "t6_reset");
            push(b + 6, k, 0, "t6_post1");
            push(b + 7, k, 0, "t6_post2");
        end
        step();
        reset = 1'b0;
        repeat (6) step();

        // T5: small instance, saturation and unmapped channel
        r0 = 0;
        p0 = 0;
        for (int j = 0; j < 40; j++) begin
            v0 = int'(j % 2 == 0);
            tp2[9] = v0[0];
            if (v0 == 1 && p0 == 0) r0++;
            push(cyc + 3, 4, v0, "t5_out");
            push(cyc + 3, 5, (r0 > 15) ? 15 : r0, "t5_cnt");
            p0 = v0;
            step();
        end
        repeat (4) step();
        push(cyc, 5, 15, "t5_sat");
        clr2 = 1'b1;
        push(cyc + 1, 5, 0, "t5_clr");
        step();
        clr2 = 1'b0;
        sel2 = 4'hD;
        repeat (6) step();
        for (int j = 0; j < 10; j++) begin
            tp2 = (j % 2 == 0) ? 12'hFFF : 12'h000;
            push(cyc + 3, 4, 0, "t5_ch3_out");
            push(cyc + 3, 5, 0, "t5_ch3_cnt");
            step();
        end
        repeat (6) step();

        check("sb_drain", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
